alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one ALU instance between two requesters (0 = EX stage, 1 = address/branch-compare unit).
//  Round-robin arbitration with valid/ready handshakes on both the request and response sides.
//  Sequences each operation around the ALU's negedge capture: drive operands, wait one cycle,
//  latch result/ZF, return them to the winning requester tagged by response lane.
// PARAMETERS
//  DATA_W   32  operand/result width
//  SIG_W    4   ALU select width
//  MAX_SIG  8   highest legal ALU select code (0..8 = add,and,nor,or,slt,sltu,sll,srl,sub)
// PORTS
//  clk          in   1          system clock (posedge logic; ALU samples on negedge)
//  rst_n        in   1          asynchronous, active-low reset
//  req_valid    in   2          per-requester request valid
//  req_ready    out  2          per-requester accept (one-hot or zero)
//  req_op1      in   2*DATA_W   operand 1, lane i at [i*DATA_W +: DATA_W]
//  req_op2      in   2*DATA_W   operand 2, same packing
//  req_shamt    in   2*5        shift amount, lane i at [i*5 +: 5]
//  req_sig      in   2*SIG_W    ALU select, lane i at [i*SIG_W +: SIG_W]
//  rsp_valid    out  2          per-requester response valid
//  rsp_ready    in   2          per-requester response accept
//  rsp_result   out  DATA_W     result (meaningful when any rsp_valid)
//  rsp_zf       out  1          zero flag
//  rsp_err      out  1          1 = illegal select, result forced 0
//  alu_op1/alu_op2 out DATA_W   to ALU operands
//  alu_shamt    out  5          to ALU shamt
//  alu_sig      out  SIG_W      to ALU ALUsignal
//  alu_result   in   DATA_W     from ALU result
//  alu_zf       in   1          from ALU ZF
// BEHAVIOUR
//  Clocking: one clock clk; reset rst_n asynchronous, active-low.
//  Reset: state=IDLE, rr_ptr=0 (req0 preferred), req_ready=0, rsp_valid=0, rsp_result=0,
//   rsp_zf=0, rsp_err=0, alu_op1/op2/shamt/sig=0.
//  FSM IDLE -> EXEC -> RESP -> IDLE:
//   IDLE: if any req_valid, winner = lane with valid; both valid -> lane rr_ptr.
//    req_ready[winner]=1 combinationally in this cycle only; operands/sig/shamt latched into
//    alu_* regs and owner reg at posedge; rr_ptr <= ~winner. Legal sig -> EXEC; sig>MAX_SIG -> RESP
//    with result 0, zf 1, err 1 (ALU not used).
//   EXEC: alu_* stable whole cycle; ALU captures at mid-cycle negedge; at posedge rsp_result<=alu_result,
//    rsp_zf<=alu_zf, rsp_err<=0 -> RESP.
//   RESP: rsp_valid[owner]=1, data held stable until rsp_ready[owner]; handshake -> IDLE.
//    rsp_ready on the non-owner lane is ignored.
//  Latency: accept in cycle N -> rsp_valid in cycle N+2 (legal op). Peak throughput 1 op / 3 cycles.
//  req_ready is never asserted outside IDLE; new request arriving during EXEC/RESP waits.
//  rr_ptr only updates on a grant; single requester always wins regardless of rr_ptr.
//  alu_* outputs hold last issued values outside EXEC (no toggling when idle).
//  Reset mid-operation: in-flight op discarded, no response issued; all outputs to reset values.
//  Never more than one bit of rsp_valid or req_ready set.
// STRUCTURE
//  alu_pkg: ALU select constants (ALU_ADD=0 .. ALU_SUB=8, ALU_SIG_MAX), state enum
//   (ST_IDLE, ST_EXEC, ST_RESP), DATA_W default.
//  Sub-module rr_arb2: 2-lane round-robin picker (valid[1:0], ptr -> grant one-hot); combinational.
//  Top holds FSM, operand/owner regs, response regs.
// TESTING
//  T1 reset: rst_n low mid-EXEC -> state IDLE, rsp_valid=00, alu_*=0, no response after release.
//  T2 single: lane0 add 5+7 in cycle N -> req_ready=01 in N, rsp_valid=01 in N+2, result 12, zf 0.
//  T3 contention: both valid, lane0 sub 9-9, lane1 or 0|0 -> lane0 served first (zf 1), lane1
//     next (zf 1); repeat with both valid -> lane1 wins (rr_ptr toggled).
//  T4 backpressure: lane1 sll op2=1 shamt=4, rsp_ready=0 for 5 cycles -> rsp_valid held, result 16
//     stable; lane0 request waits, req_ready=00 throughout.
//  T5 illegal: lane0 sig=12 -> rsp_valid=01 at N+1, result 0, zf 1, err 1; ALU outputs unchanged.
//  T6 slt/sltu: op1=0xFFFFFFFF op2=1 -> slt result 1, sltu result 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU select codes, FSM state
// encoding and small helper functions used by the arbiter top.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_SIG_W  = 4;

    // ALU select codes understood by the shared ALU
    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_AND     = 4'd1;
    localparam logic [3:0] ALU_NOR     = 4'd2;
    localparam logic [3:0] ALU_OR      = 4'd3;
    localparam logic [3:0] ALU_SLT     = 4'd4;
    localparam logic [3:0] ALU_SLTU    = 4'd5;
    localparam logic [3:0] ALU_SLL     = 4'd6;
    localparam logic [3:0] ALU_SRL     = 4'd7;
    localparam logic [3:0] ALU_SUB     = 4'd8;
    localparam logic [3:0] ALU_SIG_MAX = ALU_SUB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True when a select code is within the range the ALU implements.
    function automatic logic sig_legal(input logic [31:0] sig, input logic [31:0] max_sig);
        return (sig <= max_sig);
    endfunction

    // Expand a lane index into a one-hot lane mask.
    function automatic logic [1:0] lane_onehot(input logic lane);
        return lane ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-lane round-robin picker. A lone requester always wins; when both
// lanes request, the lane named by ptr wins. Purely combinational.
module rr_arb2
    import alu_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    // Pick the winning lane from the valid mask and the priority pointer
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters (lane 0 = EX stage,
// lane 1 = address/branch-compare unit). Each accepted operation drives the
// ALU operand registers for one full cycle so the ALU can capture them on
// the mid-cycle negedge, then latches the ALU result and returns it on the
// owner's response lane. Illegal select codes bypass the ALU entirely and
// answer one cycle earlier with result 0, zf 1, err 1.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int SIG_W   = ALU_SIG_W,
    parameter int MAX_SIG = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_op1,
    input  logic [2*DATA_W-1:0] req_op2,
    input  logic [9:0]          req_shamt,
    input  logic [2*SIG_W-1:0]  req_sig,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_result,
    output logic                rsp_zf,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   alu_op1,
    output logic [DATA_W-1:0]   alu_op2,
    output logic [4:0]          alu_shamt,
    output logic [SIG_W-1:0]    alu_sig,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_zf
);

    state_t              state_r;
    logic                rr_ptr_r;
    logic                owner_r;
    logic [1:0]          rsp_valid_r;
    logic [DATA_W-1:0]   rsp_result_r;
    logic                rsp_zf_r;
    logic                rsp_err_r;
    logic [DATA_W-1:0]   alu_op1_r;
    logic [DATA_W-1:0]   alu_op2_r;
    logic [4:0]          alu_shamt_r;
    logic [SIG_W-1:0]    alu_sig_r;

    logic [1:0]          grant_s;
    logic                win_s;
    logic                win_legal_s;
    logic [DATA_W-1:0]   win_op1_s;
    logic [DATA_W-1:0]   win_op2_s;
    logic [4:0]          win_shamt_s;
    logic [SIG_W-1:0]    win_sig_s;

    rr_arb2 u_rr_arb2 (
        .valid (req_valid),
        .ptr   (rr_ptr_r),
        .grant (grant_s)
    );

    // Steer the winning lane's operands and decide whether its select is legal
    always_comb begin
        win_s       = grant_s[1];
        win_op1_s   = req_op1[DATA_W-1:0];
        win_op2_s   = req_op2[DATA_W-1:0];
        win_shamt_s = req_shamt[4:0];
        win_sig_s   = req_sig[SIG_W-1:0];
        if (win_s) begin
            win_op1_s   = req_op1[2*DATA_W-1:DATA_W];
            win_op2_s   = req_op2[2*DATA_W-1:DATA_W];
            win_shamt_s = req_shamt[9:5];
            win_sig_s   = req_sig[2*SIG_W-1:SIG_W];
        end else begin
            win_op1_s   = req_op1[DATA_W-1:0];
            win_op2_s   = req_op2[DATA_W-1:0];
            win_shamt_s = req_shamt[4:0];
            win_sig_s   = req_sig[SIG_W-1:0];
        end
        win_legal_s = sig_legal(32'(win_sig_s), 32'(MAX_SIG));
    end

    // Accept is offered only while idle, and only to the arbitration winner
    always_comb begin
        req_ready = 2'b00;
        if (state_r == ST_IDLE) begin
            req_ready = grant_s;
        end else begin
            req_ready = 2'b00;
        end
    end

    // Sequencing FSM: grant, hold operands across the ALU capture, respond
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= 1'b0;
            owner_r      <= 1'b0;
            rsp_valid_r  <= 2'b00;
            rsp_result_r <= '0;
            rsp_zf_r     <= 1'b0;
            rsp_err_r    <= 1'b0;
            alu_op1_r    <= '0;
            alu_op2_r    <= '0;
            alu_shamt_r  <= 5'd0;
            alu_sig_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s != 2'b00) begin
                        owner_r  <= win_s;
                        rr_ptr_r <= ~win_s;
                        if (win_legal_s) begin
                            // ALU operands change only on a legal issue
                            alu_op1_r   <= win_op1_s;
                            alu_op2_r   <= win_op2_s;
                            alu_shamt_r <= win_shamt_s;
                            alu_sig_r   <= win_sig_s;
                            state_r     <= ST_EXEC;
                        end else begin
                            rsp_result_r <= '0;
                            rsp_zf_r     <= 1'b1;
                            rsp_err_r    <= 1'b1;
                            rsp_valid_r  <= lane_onehot(win_s);
                            state_r      <= ST_RESP;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    // ALU sampled the held operands on the preceding negedge
                    rsp_result_r <= alu_result;
                    rsp_zf_r     <= alu_zf;
                    rsp_err_r    <= 1'b0;
                    rsp_valid_r  <= lane_onehot(owner_r);
                    state_r      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[owner_r]) begin
                        rsp_valid_r <= 2'b00;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 2'b00;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;
    assign rsp_zf     = rsp_zf_r;
    assign rsp_err    = rsp_err_r;
    assign alu_op1    = alu_op1_r;
    assign alu_op2    = alu_op2_r;
    assign alu_shamt  = alu_shamt_r;
    assign alu_sig    = alu_sig_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. A behavioural ALU samples the arbiter's
// alu_* outputs on the negedge, as the real ALU does; all expected values
// are hand-computed constants.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_op1;
    logic [63:0] req_op2;
    logic [9:0]  req_shamt;
    logic [7:0]  req_sig;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zf;
    logic        rsp_err;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_sig;
    logic [31:0] alu_result;
    logic        alu_zf;

    int vectors;
    int miscompares;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_shamt  (req_shamt),
        .req_sig    (req_sig),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zf     (rsp_zf),
        .rsp_err    (rsp_err),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_shamt  (alu_shamt),
        .alu_sig    (alu_sig),
        .alu_result (alu_result),
        .alu_zf     (alu_zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sh, input logic [3:0] s);
        case (s)
            4'd0:    return a + b;
            4'd1:    return a & b;
            4'd2:    return ~(a | b);
            4'd3:    return a | b;
            4'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5:    return (a < b) ? 32'd1 : 32'd0;
            4'd6:    return b << sh;
            4'd7:    return b >> sh;
            4'd8:    return a - b;
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural ALU capturing its inputs on the falling edge
    always @(negedge clk) begin
        alu_result <= alu_fn(alu_op1, alu_op2, alu_shamt, alu_sig);
        alu_zf     <= (alu_fn(alu_op1, alu_op2, alu_shamt, alu_sig) == 32'd0);
    end

    task automatic set_req(input int lane, input logic [31:0] op1, input logic [31:0] op2,
                           input logic [4:0] sh, input logic [3:0] s);
        req_op1[lane*32 +: 32] = op1;
        req_op2[lane*32 +: 32] = op2;
        req_shamt[lane*5 +: 5] = sh;
        req_sig[lane*4 +: 4]   = s;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b exp 00", req_ready); end
        vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid: got %b exp 00", rsp_valid); end
        vectors++; if ({rsp_result, rsp_zf, rsp_err} !== 34'd0) begin miscompares++; $display("FAIL reset_rsp_data: got %h/%b/%b exp 0/0/0", rsp_result, rsp_zf, rsp_err); end
        vectors++; if ({alu_op1, alu_op2, alu_shamt, alu_sig} !== 73'd0) begin miscompares++; $display("FAIL reset_alu_regs: got %h %h %h %h exp all 0", alu_op1, alu_op2, alu_shamt, alu_sig); end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        @(posedge clk); #1;
        set_req(0, 32'd5, 32'd7, 5'd0, 4'd0);
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        @(negedge clk);
        vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL single_ready: got %b exp 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        vectors++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin miscompares++; $display("FAIL single_exec: got ready %b valid %b exp 00 00", req_ready, rsp_valid); end
        vectors++; if (alu_op1 !== 32'd5 || alu_op2 !== 32'd7 || alu_sig !== 4'd0) begin miscompares++; $display("FAIL single_alu_drive: got %h %h %h exp 5 7 0", alu_op1, alu_op2, alu_sig); end
        @(negedge clk);
        vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL single_rsp_valid: got %b exp 01", rsp_valid); end
        vectors++; if (rsp_result !== 32'd12 || rsp_zf !== 1'b0 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL single_rsp_data: got %h/%b/%b exp c/0/0", rsp_result, rsp_zf, rsp_err); end
        @(negedge clk);
        vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL single_rsp_done: got %b exp 00", rsp_valid); end
    endtask

    task automatic test_reset_mid_exec;
        @(posedge clk); #1;
        set_req(1, 32'd3, 32'd4, 5'd0, 4'd0);
        req_valid = 2'b10;
        @(negedge clk);
        vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL rst_mid_ready: got %b exp 10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL rst_mid_rsp_valid: got %b exp 00", rsp_valid); end
        vectors++; if ({alu_op1, alu_op2, alu_shamt, alu_sig} !== 73'd0) begin miscompares++; $display("FAIL rst_mid_alu_regs: got %h %h %h %h exp all 0", alu_op1, alu_op2, alu_shamt, alu_sig); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin miscompares++; $display("FAIL rst_mid_quiet: cycle %0d got valid %b ready %b exp 00 00", k, rsp_valid, req_ready); end
        end
    endtask

    task automatic test_contention;
        logic [1:0] exp_lane;
        @(posedge clk); #1;
        set_req(0, 32'd9, 32'd9, 5'd0, 4'd8);
        set_req(1, 32'd0, 32'd0, 5'd0, 4'd3);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int g = 0; g < 3; g++) begin
            exp_lane = (g == 1) ? 2'b10 : 2'b01;
            @(negedge clk);
            vectors++; if (req_ready !== exp_lane) begin miscompares++; $display("FAIL contend_grant: round %0d got %b exp %b", g, req_ready, exp_lane); end
            @(negedge clk);
            vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL contend_exec_ready: round %0d got %b exp 00", g, req_ready); end
            @(negedge clk);
            vectors++; if (rsp_valid !== exp_lane) begin miscompares++; $display("FAIL contend_rsp_lane: round %0d got %b exp %b", g, rsp_valid, exp_lane); end
            vectors++; if (rsp_result !== 32'd0 || rsp_zf !== 1'b1 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL contend_rsp_data: round %0d got %h/%b/%b exp 0/1/0", g, rsp_result, rsp_zf, rsp_err); end
            if (g == 2) req_valid = 2'b00;
        end
    endtask

    task automatic test_backpressure;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        set_req(1, 32'd0, 32'd1, 5'd4, 4'd6);
        req_valid = 2'b10;
        @(negedge clk);
        vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL bp_grant: got %b exp 10", req_ready); end
        @(posedge clk); #1;
        set_req(0, 32'd1, 32'd2, 5'd0, 4'd12);
        req_valid = 2'b01;
        @(negedge clk);
        vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL bp_exec_ready: got %b exp 00", req_ready); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++; if (rsp_valid !== 2'b10 || req_ready !== 2'b00) begin miscompares++; $display("FAIL bp_hold: cycle %0d got valid %b ready %b exp 10 00", k, rsp_valid, req_ready); end
            vectors++; if (rsp_result !== 32'd16 || rsp_zf !== 1'b0) begin miscompares++; $display("FAIL bp_data: cycle %0d got %h/%b exp 10/0", k, rsp_result, rsp_zf); end
        end
        @(posedge clk); #1;
        rsp_ready = 2'b01;
        @(negedge clk);
        vectors++; if (rsp_valid !== 2'b10 || req_ready !== 2'b00) begin miscompares++; $display("FAIL bp_wrong_lane_ready: got valid %b ready %b exp 10 00", rsp_valid, req_ready); end
        @(posedge clk); #1;
        rsp_ready = 2'b10;
        @(negedge clk);
        vectors++; if (rsp_valid !== 2'b10) begin miscompares++; $display("FAIL bp_last_resp: got %b exp 10", rsp_valid); end
        @(posedge clk); #1;
        rsp_ready = 2'b11;
    endtask

    task automatic test_illegal;
        @(negedge clk);
        vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL illegal_grant: got %b exp 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL illegal_rsp_valid: got %b exp 01", rsp_valid); end
        vectors++; if (rsp_result !== 32'd0 || rsp_zf !== 1'b1 || rsp_err !== 1'b1) begin miscompares++; $display("FAIL illegal_rsp_data: got %h/%b/%b exp 0/1/1", rsp_result, rsp_zf, rsp_err); end
        vectors++; if (alu_op1 !== 32'd0 || alu_op2 !== 32'd1 || alu_shamt !== 5'd4 || alu_sig !== 4'd6) begin miscompares++; $display("FAIL illegal_alu_unchanged: got %h %h %h %h exp 0 1 4 6", alu_op1, alu_op2, alu_shamt, alu_sig); end
        @(negedge clk);
        vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL illegal_done: got %b exp 00", rsp_valid); end
    endtask

    task automatic test_misc_ops;
        logic [31:0] v_op1 [5];
        logic [31:0] v_op2 [5];
        logic [4:0]  v_sh  [5];
        logic [3:0]  v_sig [5];
        logic [31:0] v_res [5];
        logic        v_zf  [5];
        v_op1[0] = 32'hFFFF_FFFF; v_op2[0] = 32'd1;          v_sh[0] = 5'd0;  v_sig[0] = 4'd4; v_res[0] = 32'd1;          v_zf[0] = 1'b0;
        v_op1[1] = 32'hFFFF_FFFF; v_op2[1] = 32'd1;          v_sh[1] = 5'd0;  v_sig[1] = 4'd5; v_res[1] = 32'd0;          v_zf[1] = 1'b1;
        v_op1[2] = 32'hFF00_FF00; v_op2[2] = 32'h0FF0_0FF0; v_sh[2] = 5'd0;  v_sig[2] = 4'd1; v_res[2] = 32'h0F00_0F00; v_zf[2] = 1'b0;
        v_op1[3] = 32'd0;         v_op2[3] = 32'h8000_0000; v_sh[3] = 5'd31; v_sig[3] = 4'd7; v_res[3] = 32'd1;          v_zf[3] = 1'b0;
        v_op1[4] = 32'd0;         v_op2[4] = 32'd0;          v_sh[4] = 5'd0;  v_sig[4] = 4'd2; v_res[4] = 32'hFFFF_FFFF; v_zf[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            set_req(0, v_op1[i], v_op2[i], v_sh[i], v_sig[i]);
            req_valid = 2'b01;
            @(negedge clk);
            vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL ops_grant: vec %0d got %b exp 01", i, req_ready); end
            @(posedge clk); #1;
            req_valid = 2'b00;
            @(negedge clk);
            @(negedge clk);
            vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL ops_rsp_valid: vec %0d got %b exp 01", i, rsp_valid); end
            vectors++; if (rsp_result !== v_res[i] || rsp_zf !== v_zf[i] || rsp_err !== 1'b0) begin miscompares++; $display("FAIL ops_rsp_data: vec %0d got %h/%b/%b exp %h/%b/0", i, rsp_result, rsp_zf, rsp_err, v_res[i], v_zf[i]); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_valid   = 2'b00;
        rsp_ready   = 2'b00;
        req_op1     = 64'd0;
        req_op2     = 64'd0;
        req_shamt   = 10'd0;
        req_sig     = 8'd0;
        test_reset;
        test_single;
        test_reset_mid_exec;
        test_contention;
        test_backpressure;
        test_illegal;
        test_misc_ops;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
